// File: rtl/stack_frame_ctrl_if.sv
// stack_frame_ctrl_if: bundle of the decoder request/response signals and the
// SuperStack op bus used by stack_frame_ctrl.
//   master : controller side (drives ready/done/err/frame_depth and stk_* ops)
//   slave  : environment side (decoder requests and SuperStack status)
// Also provides the SuperStack op codes shared with the stack.

`ifndef SS_OPS_DEFINED
`define SS_OPS_DEFINED
`define NONE                 3'd0
`define INDEX_RESET          3'd4
`define INDEX_RESET_AND_PUSH 3'd5
`endif

interface stack_frame_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1,
    parameter int FRAMES = 4
);
    localparam int FW = $clog2(FRAMES + 1);

    // decoder side
    logic             call_valid;
    logic [DEPTH:0]   call_nargs;
    logic             ret_valid;
    logic             ret_has_result;
    logic             ready;
    logic             done;
    logic [2:0]       err;
    logic [FW-1:0]    frame_depth;

    // SuperStack side
    logic             stk_own;
    logic [2:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [DEPTH:0]   stk_offset;
    logic [DEPTH:0]   stk_underflow_limit;
    logic [DEPTH:0]   stk_index;
    logic [WIDTH-1:0] stk_out;
    logic [1:0]       stk_error;

    modport master (
        input  call_valid, call_nargs, ret_valid, ret_has_result,
        input  stk_index, stk_out, stk_error,
        output ready, done, err, frame_depth,
        output stk_own, stk_op, stk_data, stk_offset, stk_underflow_limit
    );

    modport slave (
        output call_valid, call_nargs, ret_valid, ret_has_result,
        output stk_index, stk_out, stk_error,
        input  ready, done, err, frame_depth,
        input  stk_own, stk_op, stk_data, stk_offset, stk_underflow_limit
    );
endinterface

// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: call/return sequencer driving the SuperStack op bus.
// A call raises underflow_limit to the new frame base (protecting the caller's
// operands) and saves the old limit. A return collapses the frame to its base,
// optionally re-pushes the result, and restores the caller's limit.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stack_frame_ctrl_if.master (requests, status, stk_* op bus)
// All outputs are registered.

module stack_frame_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1,
    parameter int FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    stack_frame_ctrl_if.master bus
);
    localparam int FW = $clog2(FRAMES + 1);
    localparam logic [1:0] ERR_NONE = 2'd0;

    typedef enum logic [1:0] {S_IDLE, S_RET_OP, S_RET_CHK, S_DONE} state_t;

    state_t           r_state, w_nstate;
    logic             r_ready, r_done, r_own;
    logic [2:0]       r_err, w_err;
    logic [FW-1:0]    r_depth, w_depth;
    logic [2:0]       r_op, w_op;
    logic [WIDTH-1:0] r_data, w_data;
    logic [DEPTH:0]   r_offset, w_offset;
    logic [DEPTH:0]   r_limit, w_limit;
    logic             w_own, w_save_we;
    logic [DEPTH:0]   w_avail, w_save_top;
    logic [DEPTH:0]   r_save [FRAMES];

    assign w_avail = bus.stk_index - r_limit;

    // caller's saved limit for the innermost frame (save[frame_depth-1])
    always_comb begin
        w_save_top = '0;
        for (int i = 0; i < FRAMES; i++)
            if (FW'(i + 1) == r_depth) w_save_top = r_save[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nstate;
    end

    always_comb begin
        w_nstate  = r_state;
        w_err     = r_err;
        w_depth   = r_depth;
        w_limit   = r_limit;
        w_own     = 1'b0;
        w_op      = `NONE;
        w_data    = '0;
        w_offset  = '0;
        w_save_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                // return wins over a simultaneous call; the call stays pending
                if (bus.ret_valid) begin
                    w_nstate = S_DONE;
                    if (r_depth == '0)
                        w_err = 3'd2;
                    else if (bus.ret_has_result && w_avail == '0)
                        w_err = 3'd4;
                    else begin
                        // op bus values for RET_OP are set up here so they
                        // leave registers during that cycle
                        w_nstate = S_RET_OP;
                        w_own    = 1'b1;
                        w_offset = r_limit;
                        w_op     = bus.ret_has_result ? `INDEX_RESET_AND_PUSH
                                                      : `INDEX_RESET;
                        w_data   = bus.ret_has_result ? bus.stk_out : '0;
                    end
                end else if (bus.call_valid) begin
                    w_nstate = S_DONE;
                    if (r_depth == FW'(FRAMES))
                        w_err = 3'd1;
                    else if (bus.call_nargs > w_avail)
                        w_err = 3'd3;
                    else begin
                        w_err     = 3'd0;
                        w_save_we = 1'b1;
                        w_limit   = bus.stk_index - bus.call_nargs;
                        w_depth   = r_depth + FW'(1);
                    end
                end
            end
            S_RET_OP: begin
                w_nstate = S_RET_CHK;
                w_limit  = w_save_top;
                w_depth  = r_depth - FW'(1);
            end
            S_RET_CHK: begin
                // frame is already popped; only the status is reported
                w_nstate = S_DONE;
                w_err    = (bus.stk_error != ERR_NONE) ? 3'd5 : 3'd0;
            end
            S_DONE: w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= '0;
            r_depth  <= '0;
            r_own    <= 1'b0;
            r_op     <= `NONE;
            r_data   <= '0;
            r_offset <= '0;
            r_limit  <= '0;
            for (int i = 0; i < FRAMES; i++) r_save[i] <= '0;
        end else begin
            r_ready  <= (w_nstate == S_IDLE);
            r_done   <= (w_nstate == S_DONE);
            r_err    <= w_err;
            r_depth  <= w_depth;
            r_own    <= w_own;
            r_op     <= w_op;
            r_data   <= w_data;
            r_offset <= w_offset;
            r_limit  <= w_limit;
            for (int i = 0; i < FRAMES; i++)
                if (w_save_we && FW'(i) == r_depth) r_save[i] <= r_limit;
        end
    end

    assign bus.ready               = r_ready;
    assign bus.done                = r_done;
    assign bus.err                 = r_err;
    assign bus.frame_depth         = r_depth;
    assign bus.stk_own             = r_own;
    assign bus.stk_op              = r_op;
    assign bus.stk_data            = r_data;
    assign bus.stk_offset          = r_offset;
    assign bus.stk_underflow_limit = r_limit;
endmodule

// File: tb/tb_stack_frame_ctrl.sv
// tb_stack_frame_ctrl: directed bench for stack_frame_ctrl with a small
// behavioural SuperStack (push, INDEX_RESET, INDEX_RESET_AND_PUSH, error inject).
module tb_stack_frame_ctrl;
    localparam int WIDTH = 8, DEPTH = 2, FRAMES = 2;
    localparam logic [2:0] OP_NONE = 3'd0, OP_IR = 3'd4, OP_IRP = 3'd5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    stack_frame_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) bus ();

    stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural SuperStack
    logic [7:0] mem [8];
    logic [2:0] sidx;
    logic [1:0] serr;
    logic       push_req = 1'b0;
    logic [7:0] push_val = '0;
    logic       err_inj  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sidx <= '0;
            serr <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (bus.stk_own) begin
            if (bus.stk_op == OP_IRP) begin
                mem[bus.stk_offset] <= bus.stk_data;
                sidx <= bus.stk_offset + 3'd1;
            end else if (bus.stk_op == OP_IR) begin
                sidx <= bus.stk_offset;
            end
            serr <= err_inj ? 2'd1 : 2'd0;
        end else if (push_req) begin
            mem[sidx] <= push_val;
            sidx <= sidx + 3'd1;
            serr <= 2'd0;
        end
    end

    assign bus.stk_index = sidx;
    assign bus.stk_out   = (sidx == 3'd0) ? 8'd0 : mem[sidx - 3'd1];
    assign bus.stk_error = serr;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        push_req = 1'b1;
        push_val = v;
        tick();
        push_req = 1'b0;
    endtask

    task automatic do_call(input logic [2:0] nargs);
        bus.call_valid = 1'b1;
        bus.call_nargs = nargs;
        tick();
        bus.call_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.call_valid     = 1'b0;
        bus.call_nargs     = '0;
        bus.ret_valid      = 1'b0;
        bus.ret_has_result = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rst_ready", bus.ready, 1);
        chk("rst_depth", bus.frame_depth, 0);
        chk("rst_limit", bus.stk_underflow_limit, 0);
        chk("rst_op", bus.stk_op, OP_NONE);
        chk("rst_done", bus.done, 0);

        // build caller operands and open a frame with 2 arguments
        push(8'h11); push(8'h22); push(8'h33);
        chk("push_idx", bus.stk_index, 3);
        do_call(3'd2);
        chk("call_done", bus.done, 1);
        chk("call_err", bus.err, 0);
        chk("call_limit", bus.stk_underflow_limit, 1);
        chk("call_depth", bus.frame_depth, 1);
        chk("call_busy", bus.ready, 0);
        chk("call_own", bus.stk_own, 0);
        tick();
        chk("call_idle", {bus.ready, bus.done}, 2'b10);
        chk("call_avail", bus.stk_index - bus.stk_underflow_limit, 2);

        // return with result
        push(8'h2A);
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        chk("retop_own", bus.stk_own, 1);
        chk("retop_op", bus.stk_op, OP_IRP);
        chk("retop_off", bus.stk_offset, 1);
        chk("retop_data", bus.stk_data, 8'h2A);
        chk("retop_done", bus.done, 0);
        tick();
        chk("retchk_bus", {bus.stk_own, bus.stk_op, bus.stk_data}, 0);
        chk("retchk_done", bus.done, 0);
        tick();
        chk("ret_done", bus.done, 1);
        chk("ret_err", bus.err, 0);
        chk("ret_idx", bus.stk_index, 2);
        chk("ret_out", bus.stk_out, 8'h2A);
        chk("ret_out1", mem[0], 8'h11);
        chk("ret_limit", bus.stk_underflow_limit, 0);
        chk("ret_depth", bus.frame_depth, 0);
        tick();

        // return with no open frame
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b0;
        tick();
        bus.ret_valid = 1'b0;
        chk("unf_done", bus.done, 1);
        chk("unf_err", bus.err, 2);
        chk("unf_own", bus.stk_own, 0);
        tick();
        chk("unf_idx", bus.stk_index, 2);

        // too many arguments
        do_call(3'd3);
        chk("bad_err", {bus.done, bus.err}, {1'b1, 3'd3});
        chk("bad_limit", bus.stk_underflow_limit, 0);
        chk("bad_depth", bus.frame_depth, 0);
        tick();

        // frame overflow
        do_call(3'd0); tick();
        do_call(3'd0); tick();
        chk("ovf_pre", bus.frame_depth, 2);
        do_call(3'd0);
        chk("ovf_err", {bus.done, bus.err}, {1'b1, 3'd1});
        chk("ovf_depth", bus.frame_depth, 2);
        chk("ovf_limit", bus.stk_underflow_limit, 2);
        tick();

        // result requested on an empty frame
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        chk("nores_err", {bus.done, bus.err}, {1'b1, 3'd4});
        chk("nores_depth", bus.frame_depth, 2);
        tick();

        // stack error on the return op; frame still popped
        err_inj = 1'b1;
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b0;
        tick();
        bus.ret_valid = 1'b0;
        chk("serr_op", {bus.stk_op, bus.stk_offset}, {OP_IR, 3'd2});
        tick(); tick();
        err_inj = 1'b0;
        chk("serr_err", {bus.done, bus.err}, {1'b1, 3'd5});
        chk("serr_depth", bus.frame_depth, 1);
        chk("serr_limit", bus.stk_underflow_limit, 2);
        tick();

        // simultaneous call and return: return first, call held until after done
        bus.call_valid = 1'b1; bus.call_nargs = 3'd0;
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b0;
        tick();
        bus.ret_valid = 1'b0;
        chk("both_retop", {bus.stk_own, bus.stk_op, bus.ready}, {1'b1, OP_IR, 1'b0});
        tick(); tick();
        chk("both_retdone", {bus.done, bus.err, bus.frame_depth}, {1'b1, 3'd0, 2'd0});
        chk("both_limit", bus.stk_underflow_limit, 0);
        tick();
        chk("both_idle", {bus.ready, bus.done, bus.frame_depth}, {1'b1, 1'b0, 2'd0});
        tick();
        bus.call_valid = 1'b0;
        chk("both_call", {bus.done, bus.err, bus.frame_depth}, {1'b1, 3'd0, 2'd1});
        chk("both_climit", bus.stk_underflow_limit, 2);
        tick();

        // reset while in RET_OP
        push(8'h55);
        bus.ret_valid = 1'b1; bus.ret_has_result = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        chk("rrst_own", bus.stk_own, 1);
        reset = 1'b1;
        #1;
        chk("rrst_bus", {bus.stk_own, bus.stk_op, bus.stk_data, bus.stk_offset}, 0);
        chk("rrst_ctl", {bus.ready, bus.done, bus.err, bus.frame_depth}, {1'b1, 1'b0, 3'd0, 2'd0});
        chk("rrst_limit", bus.stk_underflow_limit, 0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rrst_nodone", {bus.done, bus.ready}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_frame_ctrl.md
Name: stack_frame_ctrl

Overview:
- Call/return sequencer: the initiator side of the SuperStack op interface.
- Drives SuperStack op/data/offset/underflow_limit to open and close WASM function frames.
- On call: protects the caller's operands by raising underflow_limit to the new frame base.
- On return: collapses the frame to its base, optionally re-pushes one result, and restores the caller's limit from an internal frame-save stack.
- Sits between the instruction decoder and the operand SuperStack; an external mux grants it stack ownership while stk_own=1.

Parameters:
WIDTH, 8, operand width (matches SuperStack WIDTH)
DEPTH, 1, SuperStack DEPTH; index/limit/offset width is DEPTH+1
FRAMES, 4, max nested frames held in the save stack (FW = $clog2(FRAMES+1))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
call_valid  in  1  call request
call_nargs  in  DEPTH+1  number of caller operands that become callee arguments
ret_valid  in  1  return request
ret_has_result  in  1  1 = return carries one result (current TOS)
ready  out  1  request accepted on a clk edge when valid && ready
done  out  1  one-cycle completion pulse
err  out  3  result code, valid with done: 0 OK, 1 FRAME_OVF, 2 FRAME_UNF, 3 BAD_ARGS, 4 NO_RESULT, 5 STACK_ERR
frame_depth  out  FW  current nesting depth
stk_own  out  1  controller is driving the stack op bus
stk_op  out  3  SuperStack op (`NONE/`INDEX_RESET/`INDEX_RESET_AND_PUSH)
stk_data  out  WIDTH  SuperStack data
stk_offset  out  DEPTH+1  SuperStack offset (absolute index)
stk_underflow_limit  out  DEPTH+1  SuperStack underflow_limit
stk_index  in  DEPTH+1  SuperStack index
stk_out  in  WIDTH  SuperStack TOS
stk_error  in  2  SuperStack error

Behaviour:
- Reset (async, any state): state IDLE, ready=1, done=0, err=0, frame_depth=0, stk_own=0, stk_op=`NONE, stk_data=0, stk_offset=0, stk_underflow_limit=0, save stack cleared.
- States: IDLE, RET_OP, RET_CHK, DONE.
- ready=1 only in IDLE.
- If ret_valid and call_valid are both asserted in IDLE, the return is accepted. The call is not accepted that cycle and must be held.
- Call accepted in IDLE:
  - Checks use sampled values: avail = stk_index - stk_underflow_limit.
  - frame_depth==FRAMES -> err=1, no state change.
  - call_nargs > avail -> err=3, no state change.
  - Otherwise: push current stk_underflow_limit to save[frame_depth]; stk_underflow_limit <= stk_index - call_nargs; frame_depth += 1.
  - Next state DONE. No stack op is issued; stk_own stays 0.
- Return accepted in IDLE:
  - frame_depth==0 -> err=2, go to DONE.
  - ret_has_result and avail==0 -> err=4, go to DONE.
  - Otherwise: latch result <= stk_out and base <= stk_underflow_limit; go to RET_OP.
- RET_OP (exactly one cycle):
  - stk_own=1, stk_offset=base.
  - stk_op=`INDEX_RESET_AND_PUSH with stk_data=result if has_result, else `INDEX_RESET.
  - At the end of the cycle: stk_underflow_limit <= save[frame_depth-1]; frame_depth -= 1.
- RET_CHK (one cycle):
  - stk_own=0, stk_op=`NONE.
  - stk_error != `NONE -> err=5, else err=0.
  - Frame is popped regardless of the error; go to DONE.
- DONE: done=1 for one cycle, err held; ready=0; next state IDLE.
- Error cases for call/return also pass through DONE, so done always follows an accepted request.
- Latency:
  - call: accept edge -> done in the next cycle (1 cycle).
  - return: accept -> RET_OP -> RET_CHK -> DONE (done 3 cycles after accept).
- Outputs are registered.
- Arithmetic is unsigned, DEPTH+1 bits; no wrap is possible because of the checks above.
- While stk_own=0, stk_op=`NONE and stk_data=0.
- stk_underflow_limit is always driven.
- Reset during RET_OP: the stack receives the same reset; the controller returns to reset values, with no done pulse.

Test Plan:
- Reset, then idle 3 cycles -> ready=1, frame_depth=0, stk_underflow_limit=0, stk_op=`NONE.
- DEPTH=2; push 0x11,0x22,0x33 (index 3); call nargs=2 -> next cycle done=1, err=0, stk_underflow_limit=1, frame_depth=1; stack status `NONE with 2 visible entries.
- Push 0x2A (index 4); return has_result=1:
  - RET_OP drives stk_op=`INDEX_RESET_AND_PUSH, offset=1, data=0x2A, stk_own=1.
  - done 3 cycles after accept, err=0.
  - Afterwards index=2, out=0x2A, out1=0x11, limit=0, depth=0.
- frame_depth=0, return -> done, err=2, no stack op.
- Call nargs=3 with avail=2 -> err=3, limit unchanged.
- FRAMES=2, three calls nargs=0 -> third call err=1, depth=2.
- Return has_result=1 on empty frame -> err=4.
- call_valid and ret_valid together -> return accepted, call accepted after the return's done.
- Reset asserted in RET_OP -> all outputs at reset values on the next sample.
